// File: rtl/cpu_axi_pkg.sv
// Shared constants for cpu_axi_bridge: AXI IDs, read/write FSM encodings, fixed AXI burst fields.
package cpu_axi_pkg;

  localparam int unsigned INST_ID = 0;
  localparam int unsigned DATA_ID = 1;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_AR   = 1'b1;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_REQ  = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_bridge_os_cnt.sv
// Saturating up/down counter of outstanding reads for one AXI ID; full once MAX_OS are in flight.
module axi_bridge_os_cnt
  import cpu_axi_pkg::*;
#(
  parameter int unsigned MAX_OS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full
);

  localparam int unsigned CntW = $clog2(MAX_OS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  assign full = (cnt_q >= CntW'(MAX_OS));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU inst/data SRAM-like ports onto one AXI master (shared AR, single store in flight).
// Define CPU_AXI_ADDR_RAW_EN to block data reads only on a word-address match with the pending store.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int unsigned MAX_RD_OS = 2,
  parameter int unsigned ID_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_sram_req,
  input  logic            inst_sram_wr,
  input  logic [1:0]      inst_sram_size,
  input  logic [3:0]      inst_sram_wstrb,
  input  logic [31:0]     inst_sram_addr,
  input  logic [31:0]     inst_sram_wdata,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [31:0]     inst_sram_rdata,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [3:0]      data_sram_wstrb,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [31:0]     data_sram_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic            bvalid,
  output logic            bready
);

  logic [0:0]  rd_state_q, rd_state_d;
  logic        rd_is_data_q, rd_is_data_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [1:0]  wr_state_q, wr_state_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [1:0]  wr_size_q, wr_size_d;
  logic [3:0]  wr_strb_q, wr_strb_d;

  logic inst_full, data_full, raw_block, data_rd_cand, inst_rd_cand, rd_take_data;
  logic ar_fire, aw_fire, w_fire, wr_both_done, r_fire, b_fire, r_is_inst, r_is_data;

`ifdef CPU_AXI_ADDR_RAW_EN
  assign raw_block = (wr_state_q != WR_IDLE) && (data_sram_addr[31:2] == wr_addr_q[31:2]);
`else
  assign raw_block = (wr_state_q != WR_IDLE);
`endif

  assign data_rd_cand = data_sram_req && !data_sram_wr && !data_full && !raw_block;
  assign inst_rd_cand = inst_sram_req && !inst_full;
  assign rd_take_data = (rd_state_q == RD_IDLE) && data_rd_cand;
  assign ar_fire      = arvalid && arready;

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_is_data_d = rd_is_data_q;
    rd_addr_d    = rd_addr_q;
    rd_size_d    = rd_size_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (data_rd_cand) begin
          rd_state_d   = RD_AR;
          rd_is_data_d = 1'b1;
          rd_addr_d    = data_sram_addr;
          rd_size_d    = data_sram_size;
        end else if (inst_rd_cand) begin
          rd_state_d   = RD_AR;
          rd_is_data_d = 1'b0;
          rd_addr_d    = inst_sram_addr;
          rd_size_d    = inst_sram_size;
        end
      end
      RD_AR: if (ar_fire) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign arvalid = (rd_state_q == RD_AR);
  assign arid    = rd_is_data_q ? ID_W'(DATA_ID) : ID_W'(INST_ID);
  assign araddr  = rd_addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = {1'b0, rd_size_q};
  assign arburst = AXI_BURST_INCR;

  // AW and W complete independently; the store is accepted once both have handshaken.
  assign awvalid      = (wr_state_q == WR_REQ) && !aw_done_q;
  assign wvalid       = (wr_state_q == WR_REQ) && !w_done_q;
  assign aw_fire      = awvalid && awready;
  assign w_fire       = wvalid && wready;
  assign wr_both_done = (wr_state_q == WR_REQ) && (aw_done_q || aw_fire) && (w_done_q || w_fire);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_size_d  = wr_size_q;
    wr_strb_d  = wr_strb_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (data_sram_req && data_sram_wr && !rd_take_data) begin
          wr_state_d = WR_REQ;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_addr_d  = data_sram_addr;
          wr_data_d  = data_sram_wdata;
          wr_size_d  = data_sram_size;
          wr_strb_d  = data_sram_wstrb;
        end
      end
      WR_REQ: begin
        if (wr_both_done) begin
          wr_state_d = WR_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end
      WR_RESP: if (b_fire) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign awid    = ID_W'(DATA_ID);
  assign wid     = ID_W'(DATA_ID);
  assign awaddr  = wr_addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {1'b0, wr_size_q};
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wr_data_q;
  assign wstrb   = wr_strb_q;
  assign wlast   = wvalid;

  // A data-ID R colliding with B is stalled so data_ok never has two sources in one cycle.
  assign r_is_inst = (rid == ID_W'(INST_ID));
  assign r_is_data = (rid == ID_W'(DATA_ID));
  assign bready    = 1'b1;
  assign rready    = !(rvalid && r_is_data && bvalid);
  assign r_fire    = rvalid && rready;
  assign b_fire    = bvalid && bready;

  assign inst_sram_addr_ok = ar_fire && !rd_is_data_q;
  assign data_sram_addr_ok = (ar_fire && rd_is_data_q) || wr_both_done;
  assign inst_sram_data_ok = r_fire && r_is_inst;
  assign data_sram_data_ok = (r_fire && r_is_data) || b_fire;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  axi_bridge_os_cnt #(.MAX_OS(MAX_RD_OS)) u_inst_os (
    .clk  (clk),
    .reset(reset),
    .inc  (ar_fire && !rd_is_data_q),
    .dec  (r_fire && r_is_inst),
    .full (inst_full)
  );

  axi_bridge_os_cnt #(.MAX_OS(MAX_RD_OS)) u_data_os (
    .clk  (clk),
    .reset(reset),
    .inc  (ar_fire && rd_is_data_q),
    .dec  (r_fire && r_is_data),
    .full (data_full)
  );

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rlast, bid};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q   <= RD_IDLE;
      rd_is_data_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_size_q    <= '0;
      wr_state_q   <= WR_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_size_q    <= '0;
      wr_strb_q    <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_is_data_q <= rd_is_data_d;
      rd_addr_q    <= rd_addr_d;
      rd_size_q    <= rd_size_d;
      wr_state_q   <= wr_state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_size_q    <= wr_size_d;
      wr_strb_q    <= wr_strb_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: directed AXI slave stimulus plus a response scoreboard.
module tb_cpu_axi_bridge;

  localparam int unsigned IdW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
  logic [1:0]      inst_sram_size, data_sram_size;
  logic [3:0]      inst_sram_wstrb, data_sram_wstrb;
  logic [31:0]     inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic            inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]     inst_sram_rdata, data_sram_rdata;
  logic [IdW-1:0]  arid, awid, wid, rid, bid;
  logic [31:0]     araddr, awaddr, wdata, rdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic [3:0]      wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cpu_axi_bridge #(.MAX_RD_OS(2), .ID_W(IdW)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic        is_b;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] inst_exp_q[$];
  exp_t        data_exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every data_ok pops the oldest expected response for that port.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (inst_sram_data_ok) begin
        if (inst_exp_q.size() == 0) check_eq("inst_ok_unexpected", 32'(inst_sram_data_ok), 32'd0);
        else check_eq("inst_rdata", inst_sram_rdata, inst_exp_q.pop_front());
      end
      if (data_sram_data_ok) begin
        if (data_exp_q.size() == 0) begin
          check_eq("data_ok_unexpected", 32'(data_sram_data_ok), 32'd0);
        end else begin
          mon_e = data_exp_q.pop_front();
          check_eq("data_ok_src_b", 32'(bvalid && bready), 32'(mon_e.is_b));
          if (!mon_e.is_b) check_eq("data_rdata", data_sram_rdata, mon_e.rdata);
        end
      end
    end
  end

  // Wait (bounded) for AR, check its fields, accept it and release the owner's request.
  task automatic ar_accept(input logic is_data, input logic [31:0] addr, input logic [1:0] size,
                           input int max_wait);
    bit seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      @(negedge clk);
      if (arvalid) seen = 1'b1;
      else step();
    end
    check_eq("ar_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("arid", 32'(arid), 32'(is_data));
      check_eq("araddr", araddr, addr);
      check_eq("arsize", 32'(arsize), {29'd0, 1'b0, size});
      check_eq("arlen_arburst", {22'd0, arlen, arburst}, 32'h0000_0001);
      check_eq("ar_pre_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd0);
      arready = 1'b1;
      #1;
      check_eq("ar_inst_addr_ok", 32'(inst_sram_addr_ok), 32'(!is_data));
      check_eq("ar_data_addr_ok", 32'(data_sram_addr_ok), 32'(is_data));
      step();
      arready = 1'b0;
      if (is_data) data_sram_req = 1'b0;
      else inst_sram_req = 1'b0;
    end
  endtask

  task automatic r_send(input logic is_data, input logic [31:0] data);
    if (is_data) data_exp_q.push_back({1'b0, data});
    else inst_exp_q.push_back(data);
    rvalid = 1'b1;
    rid    = is_data ? IdW'(1) : IdW'(0);
    rdata  = data;
    step();
    rvalid = 1'b0;
  endtask

  task automatic store_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_addr  = addr;
    data_sram_wdata = data;
    data_sram_wstrb = strb;
    data_sram_size  = 2'd2;
    data_exp_q.push_back({1'b1, 32'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr} = '0;
    {inst_sram_size, data_sram_size, inst_sram_wstrb, data_sram_wstrb} = '0;
    {inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata} = '0;
    {arready, awready, wready, rvalid, rlast, bvalid} = '0;
    rid = '0; bid = IdW'(1); rdata = '0;
    step();
    step();
    @(negedge clk);
    check_eq("reset_outputs", 32'({arvalid, awvalid, wvalid, rready, bready, inst_sram_addr_ok,
             data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}), 32'b0_0001_1000_0);
    reset = 1'b0;
    step();

    // 1: single inst read
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0000;
    inst_sram_size = 2'd2;
    @(negedge clk);
    check_eq("t1_ar_latency", 32'(arvalid), 32'd0);
    step();
    ar_accept(1'b0, 32'h1c00_0000, 2'd2, 4);
    r_send(1'b0, 32'h0280_0c04);
    @(negedge clk);
    check_eq("t1_data_ok_single", 32'(inst_sram_data_ok), 32'd0);
    step();

    // 2: simultaneous inst and data reads, data wins
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0100;
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h1c00_1100;
    data_sram_size = 2'd2;
    step();
    ar_accept(1'b1, 32'h1c00_1100, 2'd2, 4);
    ar_accept(1'b0, 32'h1c00_0100, 2'd2, 4);
    r_send(1'b1, 32'hd00d_0001);
    r_send(1'b0, 32'hcafe_0002);

    // 3: store, W accepted at once, AW three cycles late
    store_req(32'h1c00_1000, 32'h1122_3344, 4'hf);
    step();
    wready = 1'b1;
    @(negedge clk);
    check_eq("t3_aw_w_valid", 32'({awvalid, wvalid, wlast}), 32'b111);
    check_eq("t3_awaddr", awaddr, 32'h1c00_1000);
    check_eq("t3_wdata", wdata, 32'h1122_3344);
    check_eq("t3_ids_strb_size", 32'({awid, wid, wstrb, awsize}), {17'd0, 4'd1, 4'd1, 4'hf, 3'd2});
    check_eq("t3_addr_ok_early", 32'(data_sram_addr_ok), 32'd0);
    step();
    wready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("t3_aw_wait", 32'({awvalid, wvalid, data_sram_addr_ok}), 32'b100);
      step();
    end
    awready = 1'b1;
    @(negedge clk);
    check_eq("t3_addr_ok_on_aw", 32'(data_sram_addr_ok), 32'd1);
    step();
    awready = 1'b0;
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    @(negedge clk);
    check_eq("t3_resp_idle_valids", 32'({awvalid, wvalid}), 32'd0);
    step();
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;

    // 4: load to the stored address waits until B is accepted
    store_req(32'h1c00_1000, 32'h5566_7788, 4'hf);
    step();
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    check_eq("t4_addr_ok_same_cycle", 32'(data_sram_addr_ok), 32'd1);
    step();
    awready = 1'b0;
    wready  = 1'b0;
    data_sram_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t4_raw_hold", 32'(arvalid), 32'd0);
      step();
    end
    bvalid = 1'b1;
    @(negedge clk);
    check_eq("t4_raw_hold_b", 32'(arvalid), 32'd0);
    step();
    bvalid = 1'b0;
    ar_accept(1'b1, 32'h1c00_1000, 2'd2, 4);
    r_send(1'b1, 32'h5566_7788);
`ifdef CPU_AXI_ADDR_RAW_EN
    store_req(32'h1c00_1000, 32'h0000_00aa, 4'h1);
    step();
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h1c00_2000;
    ar_accept(1'b1, 32'h1c00_2000, 2'd2, 3);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    r_send(1'b1, 32'h2000_2000);
`endif

    // 5: R with rid=1 collides with B; B goes first
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h1c00_3000;
    data_sram_size = 2'd2;
    step();
    ar_accept(1'b1, 32'h1c00_3000, 2'd2, 4);
    store_req(32'h1c00_4000, 32'h9abc_def0, 4'hf);
    step();
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    data_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    data_exp_q.push_back({1'b0, 32'h0bad_f00d});
    rvalid = 1'b1;
    rid    = IdW'(1);
    rdata  = 32'h0bad_f00d;
    bvalid = 1'b1;
    @(negedge clk);
    check_eq("t5_b_wins", 32'({bready, rready}), 32'b10);
    step();
    bvalid = 1'b0;
    @(negedge clk);
    check_eq("t5_r_next", 32'(rready), 32'd1);
    step();
    rvalid = 1'b0;

    // 6: outstanding limit on inst reads, then reset while AR is pending
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0200;
    step();
    ar_accept(1'b0, 32'h1c00_0200, 2'd2, 4);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0204;
    ar_accept(1'b0, 32'h1c00_0204, 2'd2, 4);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0208;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t6_os_block", 32'(arvalid), 32'd0);
      step();
    end
    r_send(1'b0, 32'h0000_0a00);
    ar_accept(1'b0, 32'h1c00_0208, 2'd2, 4);
    r_send(1'b0, 32'h0000_0a04);
    r_send(1'b0, 32'h0000_0a08);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c00_0300;
    step();
    @(negedge clk);
    check_eq("t6_rd_ar", 32'(arvalid), 32'd1);
    reset = 1'b1;
    step();
    inst_sram_req = 1'b0;
    check_eq("t6_reset_arvalid", 32'(arvalid), 32'd0);
    reset = 1'b0;
    step();
    step();

    check_eq("inst_sb_drained", 32'(inst_exp_q.size()), 32'd0);
    check_eq("data_sb_drained", 32'(data_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
